// File: rtl/tick_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_mon_pkg
// Description : Shared types, defaults and helpers for the tick period monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEEK   = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } mon_state_e;

    localparam int PERIOD_DEF = 5;
    localparam int LOCK_N_DEF = 4;

    // True when value is representable in an unsigned field of the given width.
    function automatic bit fits_width(input int unsigned value, input int unsigned width);
        return (width >= 32) || (value < (32'd1 << width));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_period_mon_if.sv
`default_nettype none
// ============================================================================
// Module      : tick_period_mon_if
// Description : Stimulus/status bundle between a tick source side and the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface tick_period_mon_if #(
    parameter int CNT_W = 10,
    parameter int ERR_W = 8
);
    logic             en;
    logic             hit_in;
    logic             locked;
    logic             err_pulse;
    logic             miss;
    logic [CNT_W-1:0] last_intv;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, hit_in,
        input  locked, err_pulse, miss, last_intv, err_cnt
    );

    modport slave (
        input  en, hit_in,
        output locked, err_pulse, miss, last_intv, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/tick_intv_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tick_intv_cnt
// Description : Saturating hit-to-hit interval counter with period compare flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_intv_cnt #(
    parameter int CNT_W  = 10,
    parameter int PERIOD = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_load,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_at_period,
    output logic                  o_early
);
    localparam logic [CNT_W-1:0] c_PERIOD = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_ONE;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_at_period = (r_cnt == c_PERIOD);
    assign o_early     = (r_cnt < c_PERIOD);
endmodule
`default_nettype wire

// File: rtl/tick_period_mon.sv
`default_nettype none
// ============================================================================
// Module      : tick_period_mon
// Description : Checks a periodic hit stream against PERIOD, tracks lock and errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_period_mon
    import tick_mon_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int CNT_W  = 10,
    parameter int LOCK_N = LOCK_N_DEF,
    parameter int ERR_W  = 8
) (
    input wire logic        clk,
    input wire logic        rst,
    tick_period_mon_if.slave bus
);
    localparam logic [3:0] c_LOCK_N = 4'(LOCK_N);

    generate
        if (!fits_width(PERIOD, CNT_W) || PERIOD < 2) begin : g_bad_period
            $error("tick_period_mon: PERIOD out of range for CNT_W");
        end
        if (LOCK_N < 1 || LOCK_N > 15) begin : g_bad_lock_n
            $error("tick_period_mon: LOCK_N must be 1..15");
        end
    endgenerate

    mon_state_e       r_state;
    logic [3:0]       r_good;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_miss;
    logic [CNT_W-1:0] r_last_intv;
    logic [ERR_W-1:0] r_err_cnt;

    logic [CNT_W-1:0] w_cnt;
    logic             w_at_period;
    logic             w_early;
    logic             w_tracking;
    logic             w_good_hit;
    logic             w_early_err;
    logic             w_miss_err;
    logic             w_load;

    assign w_tracking  = bus.en && (r_state == ST_TRACK || r_state == ST_LOCKED);
    assign w_good_hit  = w_tracking && bus.hit_in && w_at_period;
    assign w_early_err = w_tracking && bus.hit_in && w_early;
    // A hit that arrives late never gets here: the timeout at PERIOD fires first.
    assign w_miss_err  = w_tracking && !bus.hit_in && w_at_period;
    assign w_load      = bus.en && bus.hit_in && (r_state != ST_IDLE);

    tick_intv_cnt #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) u_intv_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (!bus.en),
        .i_load      (w_load),
        .o_cnt       (w_cnt),
        .o_at_period (w_at_period),
        .o_early     (w_early)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_good      <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_miss      <= 1'b0;
            r_last_intv <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= w_early_err || w_miss_err;
            r_miss      <= w_miss_err;
            if ((w_early_err || w_miss_err) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end

            if (!bus.en) begin
                r_state  <= ST_IDLE;
                r_good   <= '0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_SEEK;
                        r_locked <= 1'b0;
                    end
                    ST_SEEK: begin
                        if (bus.hit_in) begin
                            r_state <= ST_TRACK;
                            r_good  <= '0;
                        end
                    end
                    default: begin
                        if (w_early_err) begin
                            r_last_intv <= w_cnt;
                            r_good      <= '0;
                            r_state     <= ST_TRACK;
                            r_locked    <= 1'b0;
                        end else if (w_miss_err) begin
                            r_state  <= ST_SEEK;
                            r_locked <= 1'b0;
                        end else if (w_good_hit) begin
                            r_last_intv <= w_cnt;
                            if (r_state == ST_TRACK) begin
                                r_good <= r_good + 4'd1;
                                if (r_good + 4'd1 == c_LOCK_N) begin
                                    r_state  <= ST_LOCKED;
                                    r_locked <= 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.miss      = r_miss;
    assign bus.last_intv = r_last_intv;
    assign bus.err_cnt   = r_err_cnt;
endmodule
`default_nettype wire
